// File: rtl/mod10_tick_counter.sv
// mod10_tick_counter
// Up/down modulo counter stepped by rising edges of an asynchronous slow tick.
// The tick is synchronized, edge-detected and gated by an arming flag so that
// a tick already high at reset release never produces a spurious step.
// Outputs the registered count, a one-cycle wrap/borrow carry, the step
// pulse and an active-low seven-segment pattern (bit order g..a).
module mod10_tick_counter #(
    parameter int MODULUS     = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       carry,
    output logic       step,
    output logic [6:0] seg
);

    localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);
    localparam logic [4:0] MOD_W5  = 5'(MODULUS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   ref_q;
    logic                   armed_q, armed_d;
    logic [3:0]             count_q, count_d;
    logic                   carry_q, carry_d;
    logic                   tick_s;
    logic                   raw_edge;

    // Active-low digit pattern, bit order g..a; 10..15 shown as A b C d E F.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            4'd10:   seg_decode = 7'b0001000;
            4'd11:   seg_decode = 7'b0000011;
            4'd12:   seg_decode = 7'b1000110;
            4'd13:   seg_decode = 7'b0100001;
            4'd14:   seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    assign tick_s   = sync_q[SYNC_STAGES-1];
    assign raw_edge = tick_s & ~ref_q;
    assign step     = raw_edge & en & armed_q;

    // Synchronizer chain, edge reference and a fill marker that tells when the
    // chain holds genuinely sampled values rather than reset zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            ref_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            ref_q  <= tick_s;
        end
    end

    // Arm once a real low level of the tick has come through the chain.
    always_comb begin
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~tick_s);
    end

    // Next count: load wins over a step; wrap and borrow raise carry.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_val} < MOD_W5) ? load_val : 4'd0;
        end else if (step) begin
            if (up_dn) begin
                if (count_q >= MAX_VAL) begin
                    count_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if (count_q == 4'd0) begin
                    count_d = MAX_VAL;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end
    end

    // Counter, carry and arming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
            carry_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            armed_q <= armed_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign seg   = seg_decode(count_q);

endmodule

// File: tb/tb_mod10_tick_counter.sv
// Bench for mod10_tick_counter: directed scenarios plus randomized tick
// pulses, checked against an arithmetic model of the counter.
module tb_mod10_tick_counter;

    localparam int MOD  = 10;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       carry;
    logic       step;
    logic [6:0] seg;

    int n_checks = 0;
    int n_fail   = 0;
    int m_count  = 0;
    int m_carry  = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    mod10_tick_counter #(.MODULUS(MOD), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count), .carry(carry),
        .step(step), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of one accepted step or load, in plain modular arithmetic.
    task automatic model_update(input bit en_v, input bit up_v, input bit do_load,
                                input int lval);
        m_carry = 0;
        if (do_load) begin
            m_count = (lval >= MOD) ? 0 : lval;
        end else if (en_v) begin
            if (up_v) begin
                m_carry = (m_count + 1 == MOD) ? 1 : 0;
                m_count = (m_count + 1) % MOD;
            end else begin
                m_carry = (m_count == 0) ? 1 : 0;
                m_count = (m_count + MOD - 1) % MOD;
            end
        end
    endtask

    // One tick pulse raised 1 ns after a clock edge; count must move on the
    // third following edge, with an optional load in the step cycle.
    task automatic tick_pulse(input bit en_v, input bit up_v, input bit do_load,
                              input int lval, input int hi, input int lo);
        int old;
        en    = en_v;
        up_dn = up_v;
        @(posedge clk); #1;
        tick_in = 1'b1;
        old = m_count;
        model_update(en_v, up_v, do_load, lval);
        for (int k = 1; k <= 4 + lo; k++) begin
            @(posedge clk); #1;
            if (k == hi) tick_in = 1'b0;
            if (k == 1) begin
                chk("step_e1", int'(step), 0);
                chk("hold_e1", int'(count), old);
            end else if (k == 2) begin
                chk("step_e2", int'(step), int'(en_v));
                chk("hold_e2", int'(count), old);
                if (do_load) begin
                    load     = 1'b1;
                    load_val = 4'(lval);
                end
            end else if (k == 3) begin
                load = 1'b0;
                chk("count_e3", int'(count), m_count);
                chk("carry_e3", int'(carry), m_carry);
                chk("step_e3", int'(step), 0);
                chk("seg_e3", int'(seg), int'(seg_tab[m_count]));
            end else if (k == 4) begin
                chk("carry_e4", int'(carry), 0);
            end
        end
    endtask

    task automatic load_only(input int lval);
        @(posedge clk); #1;
        load     = 1'b1;
        load_val = 4'(lval);
        @(posedge clk); #1;
        load = 1'b0;
        model_update(1'b0, 1'b0, 1'b1, lval);
        chk("load_count", int'(count), m_count);
        chk("load_carry", int'(carry), 0);
        chk("load_seg", int'(seg), int'(seg_tab[m_count]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick_in = 1'b0; en = 1'b0; up_dn = 1'b1;
        load = 1'b0; load_val = 4'd0;
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_seg", int'(seg), int'(7'b1000000));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_seg", int'(seg), int'(7'b1000000));
        repeat (5) @(posedge clk);
        #1;

        // Up counting through a wrap
        for (int i = 0; i < 12; i++) tick_pulse(1'b1, 1'b1, 1'b0, 0, 2, 2);
        chk("up_final", int'(count), 2);

        // Down counting through a borrow
        load_only(2);
        for (int i = 0; i < 3; i++) tick_pulse(1'b1, 1'b0, 1'b0, 0, 2, 2);
        chk("down_final", int'(count), 9);

        // Load against a step in the same cycle
        load_only(9);
        tick_pulse(1'b1, 1'b1, 1'b1, 7, 2, 2);
        chk("ld_vs_step7", int'(count), 7);
        load_only(9);
        tick_pulse(1'b1, 1'b1, 1'b1, 12, 2, 2);
        chk("ld_vs_step12", int'(count), 0);

        // Disabled edges are dropped, not queued
        load_only(4);
        for (int i = 0; i < 5; i++) tick_pulse(1'b0, 1'b1, 1'b0, 0, 2, 2);
        chk("dis_hold", int'(count), 4);
        tick_pulse(1'b1, 1'b1, 1'b0, 0, 2, 2);
        chk("dis_then_en", int'(count), 5);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                load_only(int'($urandom_range(0, 15)));
            end else begin
                tick_pulse(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                           int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            end
        end

        // Reset while tick_in is held high
        @(posedge clk); #1;
        tick_in = 1'b1;
        reset   = 1'b1;
        #2;
        chk("rsth_count", int'(count), 0);
        chk("rsth_seg", int'(seg), int'(7'b1000000));
        @(posedge clk); #1;
        reset   = 1'b0;
        m_count = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rsth_nostep", int'(step), 0);
            chk("rsth_hold", int'(count), 0);
        end
        tick_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tick_pulse(1'b1, 1'b1, 1'b0, 0, 2, 2);
        chk("rsth_first", int'(count), 1);

        // Reset in the middle of synchronizing an edge
        @(posedge clk); #1;
        tick_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("mid_rst_count", int'(count), 0);
        @(posedge clk); #1;
        tick_in = 1'b0;
        reset   = 1'b0;
        m_count = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_hold", int'(count), 0);
        tick_pulse(1'b1, 1'b1, 1'b0, 0, 2, 2);
        chk("mid_rst_first", int'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
